race_arbiter: RTL
=================

RACE_ARBITER -- requirements
Module: race_arbiter

Interface
REQ-001 Parameter RESP_WIDTH, default 8, SHALL set the number of race results packed into one response word (legal range 1..32).
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, SHALL set the maximum RACE-state cycles before a race is abandoned (legal range 2..65535).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 start  input  1  request one race; SHALL be sampled only in IDLE.
REQ-006 finished_a  input  1  single-cycle goal pulse from counter A.
REQ-007 finished_b  input  1  single-cycle goal pulse from counter B.
REQ-008 counter_clear  output  1  synchronous clear to both counters.
REQ-009 counter_enable  output  1  count enable to both counters.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 resp_word  output  RESP_WIDTH  packed response bits.
REQ-012 resp_valid  output  1  resp_word, tie_seen, timeout_seen valid.
REQ-013 resp_ready  input  1  consumer accepts the word.
REQ-014 tie_seen  output  1  at least one race in the word was a tie.
REQ-015 timeout_seen  output  1  at least one race in the word timed out.
REQ-016 tie_count  output  8  count of ties since reset (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, RACE, RECORD, OUTPUT.
REQ-018 IDLE with start=1 SHALL go to CLEAR; start in any other state SHALL be ignored.
REQ-019 CLEAR SHALL last exactly one cycle with counter_clear=1, counter_enable=0, timeout counter zeroed, then go to RACE.
REQ-020 RACE SHALL drive counter_enable=1 and increment the timeout counter by 1 each cycle.
REQ-021 In RACE, finished_a=1 alone SHALL yield result bit 1; finished_b=1 alone SHALL yield result bit 0.
REQ-022 In RACE, finished_a=1 and finished_b=1 in the same cycle SHALL yield result bit 0 and set tie_seen.
REQ-023 In RACE, timeout counter equal to TIMEOUT_CYCLES-1 with no finished pulse SHALL yield result bit 0 and set timeout_seen; a finished pulse in that same cycle SHALL take priority over timeout.
REQ-024 On a result, FSM SHALL go to RECORD next cycle with counter_enable=0 in RECORD.
REQ-025 RECORD SHALL write the result into resp_word[bit_index], increment bit_index, then go to OUTPUT if bit_index becomes RESP_WIDTH, else IDLE.
REQ-026 finished pulses outside RACE SHALL be ignored.
REQ-027 OUTPUT SHALL hold resp_valid=1 with resp_word, tie_seen, timeout_seen stable until resp_ready=1 is sampled.
REQ-028 On the OUTPUT cycle sampling resp_ready=1, next state SHALL be IDLE with bit_index, resp_word, tie_seen, timeout_seen cleared and resp_valid=0.
REQ-029 resp_ready outside OUTPUT SHALL have no effect.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, bit_index=0, timeout counter=0, resp_word=0, resp_valid=0, busy=0, counter_clear=0, counter_enable=0, tie_seen=0, timeout_seen=0, tie_count=0.
REQ-031 reset asserted mid-race or mid-OUTPUT SHALL discard partial and pending words; no resp_valid SHALL follow deassertion without a new start sequence.

Configuration
REQ-032 Macro RACE_TIE_COUNT_EN defined: tie_count SHALL increment by 1 in each RECORD cycle holding a tie, saturating at 255, cleared only by reset.
REQ-033 Macro RACE_TIE_COUNT_EN undefined: tie_count SHALL be constant 0 and no counter logic SHALL be built; all other behaviour unchanged.

Verification
REQ-034 RESP_WIDTH=8; eight races with finished_a first on races 0,2,4,6 and finished_b first otherwise -> resp_word=8'h55, resp_valid=1, tie_seen=0, timeout_seen=0.
REQ-035 start=1 in IDLE -> counter_clear=1 for exactly one cycle, then counter_enable=1 from the following cycle until one cycle after the first finished pulse.
REQ-036 finished_a and finished_b together on race 3 of 8, others A-first -> resp_word=8'hF7, tie_seen=1, tie_count=1 with RACE_TIE_COUNT_EN, 0 without.
REQ-037 TIMEOUT_CYCLES=16, no finished pulses -> result recorded after 16 RACE cycles, bit=0, timeout_seen=1 in the completed word.
REQ-038 resp_ready held 0 for 20 cycles in OUTPUT, extra start pulses -> resp_word stable, no state change; resp_ready=1 -> IDLE next cycle, resp_valid=0.
REQ-039 reset=0 asynchronously during race 5 -> all outputs zero immediately; eight fresh races after release -> one word, no stale bits.

Source files
------------

// File: rtl/race_arbiter_if.sv
// rtl/race_arbiter_if.sv - counter handshake and response bundle for race_arbiter
interface race_arbiter_if #(
    parameter int RESP_WIDTH = 8
);
    logic                  start;
    logic                  finished_a;
    logic                  finished_b;
    logic                  counter_clear;
    logic                  counter_enable;
    logic                  busy;
    logic [RESP_WIDTH-1:0] resp_word;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  tie_seen;
    logic                  timeout_seen;
    logic [7:0]            tie_count;

    modport master (
        input  start,
        input  finished_a,
        input  finished_b,
        input  resp_ready,
        output counter_clear,
        output counter_enable,
        output busy,
        output resp_word,
        output resp_valid,
        output tie_seen,
        output timeout_seen,
        output tie_count
    );

    modport slave (
        output start,
        output finished_a,
        output finished_b,
        output resp_ready,
        input  counter_clear,
        input  counter_enable,
        input  busy,
        input  resp_word,
        input  resp_valid,
        input  tie_seen,
        input  timeout_seen,
        input  tie_count
    );
endinterface

// File: rtl/race_arbiter.sv
// rtl/race_arbiter.sv - referees races between two counters and packs results into response words
// Optional tie counter built only when RACE_TIE_COUNT_EN is defined.
module race_arbiter #(
    parameter int RESP_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic           clk,
    input  logic           reset,
    race_arbiter_if.master bus
);
    localparam int                IDX_W    = $clog2(RESP_WIDTH + 1);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(RESP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RACE,
        S_RECORD,
        S_OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           tmo_q, tmo_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [RESP_WIDTH-1:0] word_q, word_d;
    logic                  tie_seen_q, tie_seen_d;
    logic                  tmo_seen_q, tmo_seen_d;
    // Outcome of the race just finished, consumed by RECORD.
    logic                  res_bit_q, res_bit_d;
    logic                  res_tie_q, res_tie_d;
    logic                  res_tmo_q, res_tmo_d;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        word_d     = word_q;
        tie_seen_d = tie_seen_q;
        tmo_seen_d = tmo_seen_q;
        res_bit_d  = res_bit_q;
        res_tie_d  = res_tie_q;
        res_tmo_d  = res_tmo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                tmo_d   = '0;
                state_d = S_RACE;
            end
            S_RACE: begin
                tmo_d = tmo_q + 16'd1;
                // A goal pulse on the final timeout cycle still wins over the timeout.
                if (bus.finished_a || bus.finished_b) begin
                    res_bit_d = bus.finished_a & ~bus.finished_b;
                    res_tie_d = bus.finished_a & bus.finished_b;
                    res_tmo_d = 1'b0;
                    state_d   = S_RECORD;
                end else if (tmo_q == TMO_LAST) begin
                    res_bit_d = 1'b0;
                    res_tie_d = 1'b0;
                    res_tmo_d = 1'b1;
                    state_d   = S_RECORD;
                end
            end
            S_RECORD: begin
                for (int i = 0; i < RESP_WIDTH; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        word_d[i] = res_bit_q;
                    end
                end
                tie_seen_d = tie_seen_q | res_tie_q;
                tmo_seen_d = tmo_seen_q | res_tmo_q;
                idx_d      = idx_q + IDX_W'(1);
                state_d    = (idx_q == IDX_LAST) ? S_OUTPUT : S_IDLE;
            end
            S_OUTPUT: begin
                if (bus.resp_ready) begin
                    state_d    = S_IDLE;
                    idx_d      = '0;
                    word_d     = '0;
                    tie_seen_d = 1'b0;
                    tmo_seen_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            tie_seen_q <= 1'b0;
            tmo_seen_q <= 1'b0;
            res_bit_q  <= 1'b0;
            res_tie_q  <= 1'b0;
            res_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            tie_seen_q <= tie_seen_d;
            tmo_seen_q <= tmo_seen_d;
            res_bit_q  <= res_bit_d;
            res_tie_q  <= res_tie_d;
            res_tmo_q  <= res_tmo_d;
        end
    end

    assign bus.counter_clear  = (state_q == S_CLEAR);
    assign bus.counter_enable = (state_q == S_RACE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.resp_valid     = (state_q == S_OUTPUT);
    assign bus.resp_word      = word_q;
    assign bus.tie_seen       = tie_seen_q;
    assign bus.timeout_seen   = tmo_seen_q;

`ifdef RACE_TIE_COUNT_EN
    logic [7:0] tie_cnt_q, tie_cnt_d;

    always_comb begin
        tie_cnt_d = tie_cnt_q;
        if ((state_q == S_RECORD) && res_tie_q && (tie_cnt_q != 8'hFF)) begin
            tie_cnt_d = tie_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tie_cnt_q <= 8'd0;
        end else begin
            tie_cnt_q <= tie_cnt_d;
        end
    end

    assign bus.tie_count = tie_cnt_q;
`else
    assign bus.tie_count = 8'd0;
`endif

endmodule
